residue_loader_chroma8x8: RTL
=============================

# residue_loader_chroma8x8

Reads back one saved 8x8 chroma residue block and its prediction mode from the residue/mode stores filled by the chroma intra-prediction saver. It streams the 64 residues in raster order to the entropy-coding or reconstruction stage over a valid/ready handshake. It sits on the read side of the IntraPred residue memory and issues reads through single-cycle-latency synchronous read ports.

## Interface
- LENGTH, 256, luma frame height in pixels; the chroma plane is LENGTH/2 rows.
- WIDTH, 256, luma frame width in pixels; the chroma plane is WIDTH/2 columns, giving WIDTH/16 blocks per row.
- AW, 14, residue address width, equal to clog2((LENGTH/2)*(WIDTH/2)).
- Clock and reset:
  - clk  in  1  single clock; all state changes on the rising edge.
  - reset  in  1  asynchronous, active-low reset.
- Request:
  - start  in  1  one-cycle request; sampled only in IDLE.
  - mbnumber  in  9  block index, latched on accepted start.
- Status:
  - busy  out  1  high from the cycle after accept until done.
  - done  out  1  one-cycle completion pulse.
  - err  out  1  one-cycle pulse when mbnumber is out of range; coincides with done.
- Mode store port:
  - mode_rd  out  1  mode store read strobe.
  - mode_rd_addr  out  9  equals the latched mbnumber.
  - mode_rd_data  in  3  valid the cycle after mode_rd.
- Residue store port:
  - mem_rd  out  1  residue store read strobe.
  - mem_addr  out  AW  residue address.
  - mem_data  in  8  valid the cycle after mem_rd.
- Output stream:
  - out_valid  out  1  residue available.
  - out_ready  in  1  consumer accepts; a transfer occurs when out_valid and out_ready are both high.
  - out_data  out  8  residue value.
  - out_last  out  1  high with residue 63.
  - out_mode  out  3  stored mode, stable for the whole block.

## Operation
- States: IDLE, FETCH, DRAIN, FIN.
- IDLE
  - start accepted; mbnumber latched.
  - If mbnumber >= (LENGTH/16)*(WIDTH/16), go to FIN with err set and issue no reads.
  - Otherwise go to FETCH.
- Address math
  - row0 = (mb / (WIDTH/16)) * 8
  - col0 = (mb % (WIDTH/16)) * 8
  - Residue k, where i = k>>3 and j = k&7, is read from mem_addr = (row0+i)*(WIDTH/2) + col0 + j, truncated to AW bits.
- FETCH
  - The first FETCH cycle asserts mode_rd and mem_rd for k=0 together.
  - out_mode is captured the following cycle and held until the next accepted start.
- Read issue
  - Counter k runs 0..63.
  - mem_rd fires when k<64 and (fifo_count + inflight − pop) < 2, where pop = out_valid & out_ready in this cycle.
  - Returning mem_data is always written into a 2-entry output FIFO.
  - This rule guarantees the FIFO never overflows.
- FETCH → DRAIN after the read for k=63 is issued.
- DRAIN → FIN when residue 63 is transferred.
- FIN: done pulses for one cycle, busy drops, then back to IDLE.
- Stream rules
  - Once out_valid is high, out_data, out_last and out_valid hold until transfer.
  - out_last is high only on residue 63.
- start while busy is ignored, with no queuing.

## Timing
- Reset values: busy, done, err, mode_rd, mem_rd, out_valid, out_last = 0; out_data, out_mode, mode_rd_addr, mem_addr = 0; FIFO empty; state IDLE.
- Reset mid-block: reads abort immediately, the FIFO is flushed, and no done pulse is produced.
- Cycle numbering: start is sampled at edge 0, and cycle n follows edge n−1.
- In-range block:
  - Cycle 1: mode_rd, mem_rd (k=0), busy=1.
  - Cycle 3: out_valid first high, with out_mode already valid.
- With out_ready held high:
  - One residue per cycle, cycles 3..66.
  - out_last in cycle 66.
  - done in cycle 67; busy=0 from cycle 67.
  - Next start accepted in cycle 67.
- Out-of-range block: done=err=1 in cycle 1; busy never asserts; no reads.
- Backpressure: each cycle of out_ready low with a full FIFO delays done by exactly one cycle.

## Test plan
- mbnumber=0, store value = (addr & 0xFF), out_ready=1:
  - 64 beats on addresses 0..7, 128..135, …, 896..903.
  - out_last on beat 64; done in cycle 67.
- mbnumber=17 (row0=8, col0=8), mode store[17]=2:
  - First mem_addr = 1032; last mem_addr = 1935.
  - out_mode=2 throughout.
- mbnumber=5, out_ready toggling 1,0,0,1,…:
  - Every beat appears exactly once in order; data stays stable while stalled.
  - FIFO never exceeds 2 entries; done delay equals the number of stall cycles.
- mbnumber=300:
  - done=err=1 in cycle 1; mem_rd and mode_rd never assert.
- A second start pulsed during busy is ignored; a start in the done cycle is accepted and runs a full second block.
- reset driven low at beat 20:
  - All outputs 0 asynchronously.
  - After release, a fresh start on mbnumber=3 streams all 64 correct residues.

Source files
------------

// File: rtl/residue_loader_chroma8x8.sv
// Streams one saved 8x8 chroma residue block (raster order) plus its mode from the residue/mode stores.
// First beat 3 cycles after start; a 2-entry FIFO absorbs read latency so out_ready low only stalls reads.

module residue_fifo #(
  parameter  int DW    = 8,
  parameter  int DEPTH = 2,
  localparam int CW    = $clog2(DEPTH + 1),
  localparam int PW    = $clog2(DEPTH)
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          wr_vld,
  input  logic [DW-1:0] wr_dat,
  output logic          rd_vld,
  input  logic          rd_rdy,
  output logic [DW-1:0] rd_dat,
  output logic [CW-1:0] count
);

  logic [DW-1:0] mem [DEPTH];
  logic [PW-1:0] wr_ptr;
  logic [PW-1:0] rd_ptr;
  logic          wr_en;
  logic          rd_en;

  function automatic logic [PW-1:0] ptr_next(input logic [PW-1:0] p);
    return (p == PW'(DEPTH - 1)) ? '0 : p + 1'b1;
  endfunction

  assign rd_vld = (count != '0);
  assign rd_dat = mem[rd_ptr];
  assign wr_en  = wr_vld && (count != CW'(DEPTH));
  assign rd_en  = rd_vld && rd_rdy;

  // Entries are cleared on reset so the head reads as zero after a flush.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (wr_en) begin
        mem[wr_ptr] <= wr_dat;
        wr_ptr      <= ptr_next(wr_ptr);
      end
      if (rd_en) rd_ptr <= ptr_next(rd_ptr);
      case ({wr_en, rd_en})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

endmodule

module residue_loader_chroma8x8 #(
  parameter int LENGTH = 256,
  parameter int WIDTH  = 256,
  parameter int AW     = 14
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          start,
  input  logic [8:0]    mbnumber,
  output logic          busy,
  output logic          done,
  output logic          err,
  output logic          mode_rd,
  output logic [8:0]    mode_rd_addr,
  input  logic [2:0]    mode_rd_data,
  output logic          mem_rd,
  output logic [AW-1:0] mem_addr,
  input  logic [7:0]    mem_data,
  output logic          out_valid,
  input  logic          out_ready,
  output logic [7:0]    out_data,
  output logic          out_last,
  output logic [2:0]    out_mode
);

  localparam int unsigned BPR  = WIDTH / 16;
  localparam int unsigned NBLK = (LENGTH / 16) * BPR;
  localparam int unsigned CPW  = WIDTH / 2;

  typedef enum logic [1:0] {IDLE, FETCH, DRAIN, FIN} state_t;

  state_t     state_q, state_d;
  logic [8:0] mb_q;
  logic [5:0] k_q;
  logic [5:0] b_q;
  logic       first_q;
  logic       err_q;
  logic       inflight_q;
  logic       mode_pend_q;
  logic [2:0] mode_q;

  logic       accept;
  logic       in_range;
  logic       pop;
  logic       room;
  logic [1:0] fifo_count;
  logic [2:0] pending;

  assign in_range = ({23'd0, mbnumber} < NBLK);
  assign pop      = out_valid && out_ready;
  assign pending  = {1'b0, fifo_count} + {2'b0, inflight_q};
  // Count what the FIFO will hold once this cycle's pop and the in-flight return settle.
  assign room     = pending < (3'd2 + {2'b0, pop});

  assign mem_addr = AW'((32'(mb_q) / BPR * 8 + 32'(k_q[5:3])) * CPW
                        + 32'(mb_q) % BPR * 8 + 32'(k_q[2:0]));
  assign mode_rd_addr = mb_q;
  assign out_mode     = mode_q;
  assign busy         = (state_q == FETCH) || (state_q == DRAIN);
  assign done         = (state_q == FIN);
  assign err          = done && err_q;
  assign out_last     = out_valid && (b_q == 6'd63);

  residue_fifo #(.DW(8), .DEPTH(2)) u_fifo (
    .clk    (clk),
    .reset  (reset),
    .wr_vld (inflight_q),
    .wr_dat (mem_data),
    .rd_vld (out_valid),
    .rd_rdy (out_ready),
    .rd_dat (out_data),
    .count  (fifo_count)
  );

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) state_q <= IDLE;
    else        state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    accept  = 1'b0;
    mem_rd  = 1'b0;
    mode_rd = 1'b0;
    case (state_q)
      // FIN also accepts so a new block can start in the done cycle.
      IDLE, FIN: begin
        state_d = IDLE;
        if (start) begin
          accept  = 1'b1;
          state_d = in_range ? FETCH : FIN;
        end
      end
      FETCH: begin
        mode_rd = first_q;
        mem_rd  = room;
        if (room && (k_q == 6'd63)) state_d = DRAIN;
      end
      DRAIN: begin
        if (pop && (b_q == 6'd63)) state_d = FIN;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      mb_q        <= '0;
      k_q         <= '0;
      b_q         <= '0;
      first_q     <= 1'b0;
      err_q       <= 1'b0;
      inflight_q  <= 1'b0;
      mode_pend_q <= 1'b0;
      mode_q      <= '0;
    end else begin
      inflight_q  <= mem_rd;
      mode_pend_q <= mode_rd;
      if (mode_pend_q) mode_q <= mode_rd_data;
      if (accept) begin
        mb_q    <= mbnumber;
        k_q     <= '0;
        b_q     <= '0;
        first_q <= in_range;
        err_q   <= !in_range;
      end else begin
        if (mode_rd) first_q <= 1'b0;
        if (mem_rd)  k_q <= k_q + 1'b1;
        if (pop)     b_q <= b_q + 1'b1;
      end
    end
  end

endmodule
